// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: 16x oversampling UART receiver.
// The asynchronous rx line is synchronized, sampled mid-bit on a free-running
// baud tick, assembled LSB-first, and presented on dout together with a
// one-clock rx_done_tick strobe and the stop-bit status of that frame.

module uart_rx_sampler #(
    parameter int DBIT    = 8,    // data bits per frame
    parameter int SB_TICK = 16,   // ticks per stop period (16 = 1 stop bit, 32 = 2)
    parameter int DVSR    = 326   // clk cycles per 16x oversampling tick
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    // Counter widths. The oversample counter is 4 bits for one stop bit and
    // only grows when a two-stop-bit configuration needs to count past 15.
    localparam int TW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;

    localparam logic [TW-1:0] TICK_LAST = TW'(DVSR - 1);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT - 1);
    localparam logic [SW-1:0] S_MID     = SW'(7);
    localparam logic [SW-1:0] S_BIT     = SW'(15);
    localparam logic [SW-1:0] S_STOP    = SW'(SB_TICK - 1);
    localparam logic [SW-1:0] S_ONE     = SW'(1);
    localparam logic [NW-1:0] N_ONE     = NW'(1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    // Synchronizer flops; both idle high so a reset never looks like a start bit.
    logic            r_rxMeta;
    logic            r_rxSync;

    // Baud tick generator.
    logic [TW-1:0]   r_tickCnt;
    logic            w_tick;

    // Receiver state and datapath registers.
    state_t          r_state;
    state_t          w_stateNext;
    logic [SW-1:0]   r_s;
    logic [SW-1:0]   w_sNext;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   w_nNext;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] w_shiftNext;
    logic [DBIT-1:0] w_shiftIn;
    logic [DBIT-1:0] r_dout;
    logic [DBIT-1:0] w_doutNext;
    logic            r_frameErr;
    logic            w_frameErrNext;
    logic            r_doneTick;
    logic            w_doneTickNext;

    // Two-flop synchronizer bringing rx into the clk domain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rxMeta <= 1'b1;
            r_rxSync <= 1'b1;
        end else begin
            r_rxMeta <= rx;
            r_rxSync <= r_rxMeta;
        end
    end

    // Free-running baud counter; never restarted by rx activity so bit timing
    // is set purely by counting ticks from the detected start edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tickCnt <= '0;
        end else if (r_tickCnt == TICK_LAST) begin
            r_tickCnt <= '0;
        end else begin
            r_tickCnt <= r_tickCnt + TW'(1);
        end
    end

    assign w_tick = (r_tickCnt == TICK_LAST);

    // New sample enters at the MSB so that after DBIT samples the first bit
    // received sits at bit 0. Written as shifts so DBIT = 1 also elaborates.
    assign w_shiftIn = (r_shift >> 1) | (DBIT'(r_rxSync) << (DBIT - 1));

    // State and datapath registers; outputs are registered so the strobe and
    // the data it qualifies update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_frameErr <= 1'b0;
            r_doneTick <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_s        <= w_sNext;
            r_n        <= w_nNext;
            r_shift    <= w_shiftNext;
            r_dout     <= w_doutNext;
            r_frameErr <= w_frameErrNext;
            r_doneTick <= w_doneTickNext;
        end
    end

    // Next-state logic: detect the start edge, confirm it at mid-bit, sample
    // each data bit at its centre, then sample the stop bit and publish.
    always_comb begin
        w_stateNext    = r_state;
        w_sNext        = r_s;
        w_nNext        = r_n;
        w_shiftNext    = r_shift;
        w_doutNext     = r_dout;
        w_frameErrNext = r_frameErr;
        w_doneTickNext = 1'b0;

        case (r_state)
            IDLE: begin
                if (!r_rxSync) begin
                    w_sNext     = '0;
                    w_stateNext = START;
                end
            end

            START: begin
                if (w_tick) begin
                    if (r_s == S_MID) begin
                        if (!r_rxSync) begin
                            w_sNext     = '0;
                            w_nNext     = '0;
                            w_stateNext = DATA;
                        end else begin
                            w_stateNext = IDLE;
                        end
                    end else begin
                        w_sNext = r_s + S_ONE;
                    end
                end
            end

            DATA: begin
                if (w_tick) begin
                    if (r_s == S_BIT) begin
                        w_sNext     = '0;
                        w_shiftNext = w_shiftIn;
                        if (r_n == N_LAST) begin
                            w_stateNext = STOP;
                        end else begin
                            w_nNext = r_n + N_ONE;
                        end
                    end else begin
                        w_sNext = r_s + S_ONE;
                    end
                end
            end

            STOP: begin
                if (w_tick) begin
                    if (r_s == S_STOP) begin
                        w_doutNext     = r_shift;
                        w_frameErrNext = ~r_rxSync;
                        w_doneTickNext = 1'b1;
                        w_stateNext    = IDLE;
                    end else begin
                        w_sNext = r_s + S_ONE;
                    end
                end
            end

            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_doneTick;
    assign frame_err    = r_frameErr;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb_uart_rx_sampler: directed frames against a frame-level expectation
// queue. Each transmitted frame predicts its data, stop status and the
// window in which its completion strobe must appear (mid stop bit).

module tb_uart_rx_sampler;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int DVSR    = 4;
    localparam int BIT_CLK = DVSR * 16;
    // Stop bit centre is 9.5 bits after the falling edge, plus synchronizer
    // latency and up to one tick of phase uncertainty.
    localparam int DONE_EARLY = 9 * BIT_CLK + BIT_CLK / 2 - 4;
    localparam int DONE_LATE  = 9 * BIT_CLK + BIT_CLK / 2 + 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rxDoneTick;
    logic            frameErr;

    uart_rx_sampler #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .DVSR    (DVSR)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx),
        .dout         (dout),
        .rx_done_tick (rxDoneTick),
        .frame_err    (frameErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        int         earliest;
        int         latest;
    } expFrame_t;

    expFrame_t  expQ[$];
    int         vectors        = 0;
    int         miscompares    = 0;
    int         cycle          = 0;
    int         pulseCount     = 0;
    int         lastPulseCycle = 0;
    int         prevPulseCycle = 0;
    int         pulsesBefore   = 0;
    logic       prevDone       = 1'b0;
    logic [7:0] prevDout       = 8'h00;
    logic       prevFerr       = 1'b0;

    // Cycle counter used to timestamp frames and strobes.
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, required, cycle);
        end
    endtask

    // Per-cycle monitor: every strobe must match the oldest predicted frame
    // and fall in its window; between strobes the outputs must hold.
    always @(negedge clk) begin : compare
        expFrame_t e;
        if (!reset_n) begin
            prevDone = 1'b0;
            prevDout = dout;
            prevFerr = frameErr;
        end else begin
            if (rxDoneTick) begin
                checkOutput("done_single_cycle", 32'(prevDone), 32'd0);
                prevPulseCycle = lastPulseCycle;
                lastPulseCycle = cycle;
                pulseCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("dout", 32'(dout), 32'(e.data));
                    checkOutput("frame_err", 32'(frameErr), 32'(e.ferr));
                    checkOutput("pulse_in_window",
                                (cycle >= e.earliest && cycle <= e.latest) ? 32'd1 : 32'd0,
                                32'd1);
                end
            end else begin
                checkOutput("dout_hold", 32'(dout), 32'(prevDout));
                checkOutput("ferr_hold", 32'(frameErr), 32'(prevFerr));
                if (expQ.size() > 0 && cycle > expQ[0].latest) begin
                    checkOutput("pulse_missing", 32'd0, 32'd1);
                    void'(expQ.pop_front());
                end
            end
            prevDone = rxDoneTick;
            prevDout = dout;
            prevFerr = frameErr;
        end
    end

    task automatic driveBit(input logic v, input int clocks);
        rx = v;
        repeat (clocks) @(negedge clk);
    endtask

    // Sends one frame starting at the current negedge and predicts its result.
    task automatic applyStimulus(input logic [7:0] data, input logic stopBit,
                                 input int stopClocks);
        expFrame_t e;
        e.data     = data;
        e.ferr     = ~stopBit;
        e.earliest = cycle + DONE_EARLY;
        e.latest   = cycle + DONE_LATE;
        expQ.push_back(e);
        driveBit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) driveBit(data[i], BIT_CLK);
        driveBit(stopBit, stopClocks);
        rx = 1'b1;
    endtask

    initial begin
        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_dout", 32'(dout), 32'h00);
        checkOutput("reset_done", 32'(rxDoneTick), 32'd0);
        checkOutput("reset_ferr", 32'(frameErr), 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);

        // Single good frame.
        applyStimulus(8'hA5, 1'b1, BIT_CLK);
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("a5_dout_literal", 32'(dout), 32'hA5);
        checkOutput("a5_ferr_literal", 32'(frameErr), 32'd0);
        checkOutput("a5_pulse_count", 32'(pulseCount), 32'd1);

        // Back-to-back frames, no idle between stop and next start.
        pulsesBefore = pulseCount;
        applyStimulus(8'h00, 1'b1, BIT_CLK);
        applyStimulus(8'hFF, 1'b1, BIT_CLK);
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("b2b_pulse_count", 32'(pulseCount - pulsesBefore), 32'd2);
        checkOutput("b2b_spacing",
                    (lastPulseCycle - prevPulseCycle >= 10 * BIT_CLK - DVSR &&
                     lastPulseCycle - prevPulseCycle <= 10 * BIT_CLK + DVSR) ? 32'd1 : 32'd0,
                    32'd1);
        checkOutput("b2b_dout_literal", 32'(dout), 32'hFF);

        // Short low glitch must be rejected as a false start.
        pulsesBefore = pulseCount;
        driveBit(1'b0, 16);
        driveBit(1'b1, 4 * BIT_CLK);
        checkOutput("glitch_no_pulse", 32'(pulseCount - pulsesBefore), 32'd0);
        checkOutput("glitch_dout_literal", 32'(dout), 32'hFF);

        // Low stop bit held past the sample point: the trailing low is a
        // false start and must not produce a second strobe.
        pulsesBefore = pulseCount;
        applyStimulus(8'h3C, 1'b0, 44);
        repeat (2 * BIT_CLK) @(negedge clk);
        checkOutput("ferr_pulse_count", 32'(pulseCount - pulsesBefore), 32'd1);
        checkOutput("ferr_dout_literal", 32'(dout), 32'h3C);
        checkOutput("ferr_flag_literal", 32'(frameErr), 32'd1);

        applyStimulus(8'h01, 1'b1, BIT_CLK);
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("recover_dout_literal", 32'(dout), 32'h01);
        checkOutput("recover_ferr_literal", 32'(frameErr), 32'd0);

        // Reset in the middle of the 4th data bit of a 0x5A frame.
        pulsesBefore = pulseCount;
        driveBit(1'b0, BIT_CLK);
        driveBit(1'b0, BIT_CLK);
        driveBit(1'b1, BIT_CLK);
        driveBit(1'b0, BIT_CLK);
        driveBit(1'b1, BIT_CLK / 2);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset_dout", 32'(dout), 32'h00);
        checkOutput("midreset_done", 32'(rxDoneTick), 32'd0);
        checkOutput("midreset_ferr", 32'(frameErr), 32'd0);
        repeat (3) @(negedge clk);
        rx      = 1'b1;
        reset_n = 1'b1;
        repeat (11 * BIT_CLK) @(negedge clk);
        checkOutput("midreset_no_pulse", 32'(pulseCount - pulsesBefore), 32'd0);

        applyStimulus(8'h5A, 1'b1, BIT_CLK);
        repeat (BIT_CLK) @(negedge clk);
        checkOutput("after_reset_dout_literal", 32'(dout), 32'h5A);

        repeat (50) @(negedge clk);
        checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
